// File: rtl/bnn_output_layer_seq.sv
// Sequential BNN output layer: XNOR/popcount scoring of NUM_CLASSES neurons, CHUNK bits per cycle,
// with running argmax and an external combinational weight ROM. Optional macro: SCORE_OUT_EN.
module bnn_output_layer_seq #(
  parameter int unsigned NUM_INPUTS  = 196,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned CHUNK       = 28,
  localparam int unsigned NCHUNK     = (NUM_INPUTS + CHUNK - 1) / CHUNK,
  localparam int unsigned SCORE_W    = $clog2(NUM_INPUTS + 1),
  localparam int unsigned IDX_W      = $clog2(NUM_CLASSES),
  localparam int unsigned CHUNK_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_INPUTS-1:0] data_in,
  output logic [IDX_W-1:0]      w_class,
  output logic [CHUNK_W-1:0]    w_chunk,
  input  logic [CHUNK-1:0]      weights_chunk,
  output logic                  busy,
  output logic [IDX_W-1:0]      answer,
  output logic                  layer_done
`ifdef SCORE_OUT_EN
  ,
  output logic [SCORE_W-1:0]    best_score,
  output logic [SCORE_W-1:0]    margin
`endif
);

  localparam int unsigned PAD_W = NCHUNK * CHUNK;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCORE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  logic [PAD_W-1:0]   data_q, data_nxt;
  logic [SCORE_W-1:0] acc_q, acc_nxt;
  logic [SCORE_W-1:0] best_q, best_nxt;
  logic [IDX_W-1:0]   best_idx_q, best_idx_nxt;
  logic [IDX_W-1:0]   w_class_nxt, answer_nxt;
  logic [CHUNK_W-1:0] w_chunk_nxt;
  logic               busy_nxt, layer_done_nxt;
`ifdef SCORE_OUT_EN
  logic [SCORE_W-1:0] second_q, second_nxt;
  logic [SCORE_W-1:0] best_score_nxt, margin_nxt;
`endif

  int unsigned        chunk_base;
  logic [CHUNK-1:0]   data_chunk;
  logic [CHUNK-1:0]   mask;
  logic [CHUNK-1:0]   match;
  logic [SCORE_W-1:0] pc;
  logic [SCORE_W-1:0] score;
  logic               last_chunk, last_class, beats;

  // Current chunk of the latched vector; bits past NUM_INPUTS never count.
  always_comb begin : chunk_score
    chunk_base = 32'(w_chunk) * CHUNK;
    data_chunk = CHUNK'(data_q >> chunk_base);
    for (int i = 0; i < int'(CHUNK); i++) begin
      mask[i] = (chunk_base + 32'(i)) < NUM_INPUTS;
    end
    match = ~(weights_chunk ^ data_chunk) & mask;
    pc = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      pc = pc + SCORE_W'(match[i]);
    end
    score      = acc_q + pc;
    last_chunk = (w_chunk == CHUNK_W'(NCHUNK - 1));
    last_class = (w_class == IDX_W'(NUM_CLASSES - 1));
    // Class 0 seeds the argmax; later classes need a strictly higher score.
    beats      = (w_class == '0) || (score > best_q);
  end

  always_ff @(posedge clock or negedge reset) begin : state_reg
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin : next_state
    state_nxt = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_nxt = S_SCORE;
      S_SCORE:        if (last_chunk && last_class) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin : datapath_next
    data_nxt       = data_q;
    acc_nxt        = acc_q;
    best_nxt       = best_q;
    best_idx_nxt   = best_idx_q;
    w_class_nxt    = w_class;
    w_chunk_nxt    = w_chunk;
    answer_nxt     = answer;
    busy_nxt       = busy;
    layer_done_nxt = layer_done;
`ifdef SCORE_OUT_EN
    second_nxt     = second_q;
    best_score_nxt = best_score;
    margin_nxt     = margin;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          data_nxt       = PAD_W'(data_in);
          w_class_nxt    = '0;
          w_chunk_nxt    = '0;
          acc_nxt        = '0;
          layer_done_nxt = 1'b0;
          busy_nxt       = 1'b1;
        end
      end
      S_SCORE: begin
        acc_nxt     = score;
        w_chunk_nxt = CHUNK_W'(w_chunk + 1'b1);
        if (last_chunk) begin
          acc_nxt     = '0;
          w_chunk_nxt = '0;
          w_class_nxt = IDX_W'(w_class + 1'b1);
          if (beats) begin
            best_nxt     = score;
            best_idx_nxt = w_class;
          end
`ifdef SCORE_OUT_EN
          if (w_class == '0)          second_nxt = '0;
          else if (score > best_q)    second_nxt = best_q;
          else if (score > second_q)  second_nxt = score;
`endif
          if (last_class) begin
            answer_nxt     = best_idx_nxt;
            layer_done_nxt = 1'b1;
            busy_nxt       = 1'b0;
            w_class_nxt    = '0;
`ifdef SCORE_OUT_EN
            best_score_nxt = best_nxt;
            margin_nxt     = best_nxt - second_nxt;
`endif
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin : datapath_reg
    if (!reset) begin
      data_q     <= '0;
      acc_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      w_class    <= '0;
      w_chunk    <= '0;
      answer     <= '0;
      busy       <= 1'b0;
      layer_done <= 1'b0;
`ifdef SCORE_OUT_EN
      second_q   <= '0;
      best_score <= '0;
      margin     <= '0;
`endif
    end else begin
      data_q     <= data_nxt;
      acc_q      <= acc_nxt;
      best_q     <= best_nxt;
      best_idx_q <= best_idx_nxt;
      w_class    <= w_class_nxt;
      w_chunk    <= w_chunk_nxt;
      answer     <= answer_nxt;
      busy       <= busy_nxt;
      layer_done <= layer_done_nxt;
`ifdef SCORE_OUT_EN
      second_q   <= second_nxt;
      best_score <= best_score_nxt;
      margin     <= margin_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_bnn_output_layer_seq.sv
// Bench for bnn_output_layer_seq: default instance (CHUNK=28) and a padded instance (CHUNK=32)
// in lockstep against a whole-vector scoring model. Honors SCORE_OUT_EN.
module tb_bnn_output_layer_seq;

  localparam int N      = 196;
  localparam int C      = 10;
  localparam int LAT    = 70;

  logic         clock, reset, start;
  logic [195:0] data_in;
  logic [3:0]   w_class_a, w_class_b, answer_a, answer_b;
  logic [2:0]   w_chunk_a, w_chunk_b;
  logic [27:0]  wa;
  logic [31:0]  wb;
  logic         busy_a, busy_b, done_a, done_b;
`ifdef SCORE_OUT_EN
  logic [7:0]   bs_a, mg_a, bs_b, mg_b;
`endif

  logic [195:0] wmem [C];
  logic [195:0] row_a, row_b;
  logic [223:0] row_b_pad;

  int checks = 0;
  int errors = 0;

  bnn_output_layer_seq dut_a (
    .clock(clock), .reset(reset), .start(start), .data_in(data_in),
    .w_class(w_class_a), .w_chunk(w_chunk_a), .weights_chunk(wa),
    .busy(busy_a), .answer(answer_a), .layer_done(done_a)
`ifdef SCORE_OUT_EN
    , .best_score(bs_a), .margin(mg_a)
`endif
  );

  bnn_output_layer_seq #(.NUM_INPUTS(196), .NUM_CLASSES(10), .CHUNK(32)) dut_b (
    .clock(clock), .reset(reset), .start(start), .data_in(data_in),
    .w_class(w_class_b), .w_chunk(w_chunk_b), .weights_chunk(wb),
    .busy(busy_b), .answer(answer_b), .layer_done(done_b)
`ifdef SCORE_OUT_EN
    , .best_score(bs_b), .margin(mg_b)
`endif
  );

  // Combinational ROMs; the padded ROM puts zeros past bit 195 for class 5 only,
  // so unmasked padding would make class 5 win ties.
  always_comb begin
    row_a     = (int'(w_class_a) < C) ? wmem[w_class_a] : '0;
    wa        = 28'(row_a >> (int'(w_chunk_a) * 28));
    row_b     = (int'(w_class_b) < C) ? wmem[w_class_b] : '0;
    row_b_pad = {(w_class_b == 4'd5) ? 28'h0 : 28'hFFFFFFF, row_b};
    wb        = 32'(row_b_pad >> (int'(w_chunk_b) * 32));
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Whole-vector scoring: returns {winner, best, second-best} packed as 3 bytes.
  function automatic logic [23:0] eval(input logic [195:0] d);
    int s [C];
    int best, idx, second;
    for (int c = 0; c < C; c++) s[c] = $countones(~(wmem[c] ^ d));
    best = -1; idx = 0;
    for (int c = 0; c < C; c++) if (s[c] > best) begin best = s[c]; idx = c; end
    second = 0;
    for (int c = 0; c < C; c++) if (c != idx && s[c] > second) second = s[c];
    return {8'(idx), 8'(best), 8'(second)};
  endfunction

  function automatic logic [195:0] flip_low(input logic [195:0] d, input int k);
    logic [195:0] r;
    r = d;
    for (int i = 0; i < k; i++) r[i] = ~r[i];
    return r;
  endfunction

  // Transaction-level model: idle/scoring/done with a cycle count.
  int          m_mode = 0;
  int          m_cnt  = 0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [3:0]  m_ans  = '0;
  logic [7:0]  m_best = '0, m_marg = '0;
  logic [23:0] m_res  = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mode <= 0; m_cnt <= 0; m_busy <= 1'b0; m_done <= 1'b0;
      m_ans <= '0; m_best <= '0; m_marg <= '0;
    end else if (m_mode != 1 && start) begin
      m_mode <= 1; m_cnt <= 0; m_busy <= 1'b1; m_done <= 1'b0;
      m_res  <= eval(data_in);
    end else if (m_mode == 1) begin
      if (m_cnt == LAT - 1) begin
        m_mode <= 2; m_cnt <= 0; m_busy <= 1'b0; m_done <= 1'b1;
        m_ans  <= 4'(m_res[23:16]);
        m_best <= m_res[15:8];
        m_marg <= m_res[15:8] - m_res[7:0];
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  int exp_wc, exp_wk;
  always @(negedge clock) begin
    exp_wc = (m_mode == 1) ? m_cnt / 7 : 0;
    exp_wk = (m_mode == 1) ? m_cnt % 7 : 0;
    chk("busy_a", busy_a, m_busy);         chk("busy_b", busy_b, m_busy);
    chk("done_a", done_a, m_done);         chk("done_b", done_b, m_done);
    chk("answer_a", answer_a, m_ans);      chk("answer_b", answer_b, m_ans);
    chk("w_class_a", w_class_a, exp_wc);   chk("w_class_b", w_class_b, exp_wc);
    chk("w_chunk_a", w_chunk_a, exp_wk);   chk("w_chunk_b", w_chunk_b, exp_wk);
`ifdef SCORE_OUT_EN
    chk("best_a", bs_a, m_best);           chk("best_b", bs_b, m_best);
    chk("margin_a", mg_a, m_marg);         chk("margin_b", mg_b, m_marg);
`endif
  end

  task automatic do_start(input logic [195:0] d);
    @(negedge clock);
    data_in = d;
    start   = 1'b1;
    @(negedge clock);
    start   = 1'b0;
  endtask

  // Counts edges until layer_done on the default instance, bounded.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!done_a && n < 200);
    chk("done_timeout", (n < 200) ? 1 : 0, 1);
  endtask

  logic [195:0] d1, d2, d3, ones;
  int n;

  initial begin
    d1   = {7{28'hA5C396E}};
    d2   = {7{28'h1234567}};
    d3   = {7{28'h0F0F0F0}};
    ones = '1;
    reset = 1'b0; start = 1'b0; data_in = '0;
    for (int c = 0; c < C; c++) wmem[c] = '0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_answer", answer_a, 0);
    reset = 1'b1;

    // Class 3 matches exactly, all others are complements.
    for (int c = 0; c < C; c++) wmem[c] = (c == 3) ? d1 : ~d1;
    do_start(d1);
    wait_done(n);
    chk("t1_latency", n, LAT);
    chk("t1_answer_a", answer_a, 3);
    chk("t1_answer_b", answer_b, 3);
    chk("t1_model_answer", m_ans, 3);
`ifdef SCORE_OUT_EN
    chk("t1_best", bs_a, 196);
    chk("t1_margin", mg_a, 196);
`endif

    // Tie between classes 2 and 7 goes to the lower index.
    for (int c = 0; c < C; c++) wmem[c] = (c == 2 || c == 7) ? ones : '0;
    do_start(ones);
    wait_done(n);
    chk("t2_answer_a", answer_a, 2);
    chk("t2_answer_b", answer_b, 2);
    chk("t2_model_answer", m_ans, 2);
`ifdef SCORE_OUT_EN
    chk("t2_margin", mg_a, 0);
`endif

    // All classes match: padding must not add to any score.
    for (int c = 0; c < C; c++) wmem[c] = d1;
    do_start(d1);
    wait_done(n);
    chk("t3_answer_a", answer_a, 0);
    chk("t3_answer_b_masked", answer_b, 0);
    chk("t3_model_best", m_best, 196);
`ifdef SCORE_OUT_EN
    chk("t3_best_b", bs_b, 196);
    chk("t3_margin_b", mg_b, 0);
`endif

    // Reset 30 cycles into scoring aborts; rerun gives class 6.
    for (int c = 0; c < C; c++) wmem[c] = flip_low(d2, (c == 6) ? 0 : 5 + c);
    do_start(d2);
    repeat (30) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("t4_rst_busy", busy_a, 0);
    chk("t4_rst_done", done_a, 0);
    chk("t4_rst_answer", answer_a, 0);
    chk("t4_rst_w_class", w_class_a, 0);
    chk("t4_rst_w_chunk", w_chunk_a, 0);
    @(negedge clock);
    reset = 1'b1;
    do_start(d2);
    wait_done(n);
    chk("t4_latency", n, LAT);
    chk("t4_answer", answer_a, 6);

    // Start and data changes during scoring are ignored.
    for (int c = 0; c < C; c++) wmem[c] = flip_low(d3, (c == 8) ? 0 : 3 + c);
    do_start(d3);
    repeat (20) @(negedge clock);
    data_in = ~d3;
    start   = 1'b1;
    @(negedge clock);
    start   = 1'b0;
    data_in = '0;
    wait_done(n);
    chk("t5_answer", answer_a, 8);
    chk("t5_answer_b", answer_b, 8);

    // Back-to-back start in DONE; scores {10,50,40,23..29}.
    for (int c = 0; c < C; c++)
      wmem[c] = flip_low(ones, (c == 0) ? 10 : (c == 1) ? 50 : (c == 2) ? 40 : 20 + c);
    @(negedge clock);
    chk("t6_done_before", done_a, 1);
    data_in = '0;
    start   = 1'b1;
    @(posedge clock);
    #1;
    chk("t6_done_dropped", done_a, 0);
    chk("t6_busy_raised", busy_a, 1);
    start = 1'b0;
    wait_done(n);
    chk("t6_latency", n, LAT);
    chk("t6_answer", answer_a, 1);
    chk("t6_model_margin", m_marg, 10);
`ifdef SCORE_OUT_EN
    chk("t6_best", bs_a, 50);
    chk("t6_margin", mg_a, 10);
`endif

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
